// File: rtl/edp_pkg.sv
// Shared EDP definitions: AD function encodings and multiply sequencer states.
package edp_pkg;

    localparam logic [2:0] AD_A    = 3'd0;
    localparam logic [2:0] AD_APB  = 3'd1;
    localparam logic [2:0] AD_AP2B = 3'd2;
    localparam logic [2:0] AD_AMB  = 3'd3;
    localparam logic [2:0] AD_AM2B = 3'd4;

    typedef enum logic [2:0] {
        MUL_IDLE  = 3'd0,
        MUL_INIT  = 3'd1,
        MUL_STEP  = 3'd2,
        MUL_FIXUP = 3'd3,
        MUL_DONE  = 3'd4
    } mulState_t;

endpackage

// File: rtl/mul_booth_dec.sv
// Radix-4 Booth recoder: maps (MQ34, MQ35, carry) to an AD function.
// Shared with the divide sequencer, so it carries no state of its own.
module mul_booth_dec
    import edp_pkg::*;
(
    input  logic [2:0] triplet,
    output logic [2:0] adFunc
);

    // Booth digit = -2*MQ34 + MQ35 + c, expressed as an AD operation
    always_comb begin
        adFunc = AD_A;
        case (triplet)
            3'b000:  adFunc = AD_A;
            3'b001:  adFunc = AD_APB;
            3'b010:  adFunc = AD_APB;
            3'b011:  adFunc = AD_AP2B;
            3'b100:  adFunc = AD_AM2B;
            3'b101:  adFunc = AD_AMB;
            3'b110:  adFunc = AD_AMB;
            3'b111:  adFunc = AD_A;
            default: adFunc = AD_A;
        endcase
    end

endmodule

// File: rtl/edp_mul_seq.sv
// Radix-4 Booth multiply sequencer driving the EDP AD select, AR/ARX loads
// and MQ select. Control outputs are Mealy-gated by abort so a cancel takes
// effect in the same cycle it is raised.
module edp_mul_seq
    import edp_pkg::*;
#(
    parameter int STEPW = 6
) (
    input  logic             eboxClk,
    input  logic             eboxReset,
    input  logic             start,
    input  logic             abort,
    input  logic [STEPW-1:0] stepCount,
    input  logic             signedMul,
    input  logic [1:0]       MQ34_35,
    output logic             busy,
    output logic             done,
    output logic [2:0]       adFunc,
    output logic             arClr,
    output logic             arLoad,
    output logic             arxLoad,
    output logic             arShift,
    output logic             mqShift,
    output logic [STEPW-1:0] stepsLeft
);

    mulState_t        state_q;
    mulState_t        state_d;
    logic             carry_q;
    logic [STEPW-1:0] count_lat;
    logic             signed_lat;
    logic [2:0]       booth_func;
    logic             live;

    mul_booth_dec u_booth_dec (
        .triplet (MQ34_35 == 2'b00 ? {2'b00, carry_q} : {MQ34_35, carry_q}),
        .adFunc  (booth_func)
    );

    // abort cancels everything except in IDLE, where outputs are already 0
    assign live = !abort;

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE:  if (start && !abort) state_d = MUL_INIT;
            MUL_INIT:  state_d = (count_lat == '0) ? MUL_DONE : MUL_STEP;
            MUL_STEP:  if (stepsLeft == STEPW'(1))
                           state_d = (!signed_lat && MQ34_35[1]) ? MUL_FIXUP : MUL_DONE;
            MUL_FIXUP: state_d = MUL_DONE;
            MUL_DONE:  state_d = MUL_IDLE;
            default:   state_d = MUL_IDLE;
        endcase
        if (state_q != MUL_IDLE && abort) state_d = MUL_IDLE;
    end

    // State, operand latches, step counter and Booth carry
    always_ff @(posedge eboxClk or posedge eboxReset) begin
        if (eboxReset) begin
            state_q    <= MUL_IDLE;
            carry_q    <= 1'b0;
            stepsLeft  <= '0;
            count_lat  <= '0;
            signed_lat <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == MUL_IDLE && start && !abort) begin
                count_lat  <= stepCount;
                signed_lat <= signedMul;
            end
            if (!abort) begin
                if (state_q == MUL_INIT) begin
                    stepsLeft <= count_lat;
                    carry_q   <= 1'b0;
                end else if (state_q == MUL_STEP) begin
                    stepsLeft <= stepsLeft - STEPW'(1);
                    carry_q   <= MQ34_35[1];
                end
            end
        end
    end

    // Output decode from state, gated by abort
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        adFunc  = AD_A;
        arClr   = 1'b0;
        arLoad  = 1'b0;
        arxLoad = 1'b0;
        arShift = 1'b0;
        mqShift = 1'b0;
        if (live) begin
            case (state_q)
                MUL_INIT: begin
                    busy  = 1'b1;
                    arClr = 1'b1;
                end
                MUL_STEP: begin
                    busy    = 1'b1;
                    arLoad  = 1'b1;
                    arxLoad = 1'b1;
                    arShift = 1'b1;
                    mqShift = 1'b1;
                    adFunc  = booth_func;
                end
                MUL_FIXUP: begin
                    busy    = 1'b1;
                    arLoad  = 1'b1;
                    arxLoad = 1'b1;
                    adFunc  = AD_APB;
                end
                MUL_DONE: done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
